// File: rtl/branch_operand_bypass_pkg.sv
// Shared types and defaults for the decode-stage branch operand bypass unit.
// Scoreboard entries store rd zero-extended to SB_REGW so the struct stays parameter-free.
package bypass_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int NSRC_DEF       = 2;
  localparam int DEPTH_DEF      = 3;
  localparam int REGW_DEF       = 5;
  localparam int READY_ALU_DEF  = 1;
  localparam int READY_LOAD_DEF = 2;
  localparam int CNTW_DEF       = 16;

  localparam int SB_REGW = 8;
  localparam int FWD_RF  = DEPTH_DEF;

  typedef struct packed {
    logic               valid;
    logic [SB_REGW-1:0] rd;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/branch_operand_bypass_if.sv
// Decode-side bundle for the bypass unit: decode fields, operand sources, resolved operands.
// master = decode stage, slave = bypass unit.
interface branch_operand_bypass_if
  import bypass_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int CNTW  = CNTW_DEF
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                   id_valid;
  logic [NSRC*REGW-1:0]   id_rs;
  logic [NSRC-1:0]        id_rs_used;
  logic [REGW-1:0]        id_rd;
  logic                   id_regwrite;
  logic                   id_memread;
  logic                   flush;
  logic [NSRC*XLEN-1:0]   rf_data;
  logic [DEPTH*XLEN-1:0]  stage_res;
  logic [NSRC*XLEN-1:0]   op_mod;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic                   stall;
  logic [CNTW-1:0]        stall_cnt;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, flush,
           rf_data, stage_res,
    input  op_mod, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_regwrite, id_memread, flush,
           rf_data, stage_res,
    output op_mod, fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/branch_operand_bypass_src_sel.sv
// Per-source youngest-producer match, readiness check and operand mux.
// Purely combinational; hazard flags a matching producer whose result is not yet visible.
module bypass_src_sel
  import bypass_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int REGW       = REGW_DEF,
  parameter int READY_ALU  = READY_ALU_DEF,
  parameter int READY_LOAD = READY_LOAD_DEF,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic [REGW-1:0]       rs,
  input  logic                  rs_used,
  input  sb_entry_t [DEPTH-1:0] sb,
  input  logic [DEPTH*XLEN-1:0] stage_res,
  input  logic [XLEN-1:0]       rf_data,
  output logic [XLEN-1:0]       op_mod,
  output logic [SELW-1:0]       fwd_sel,
  output logic                  hazard
);

  logic [SB_REGW-1:0] rs_ext;
  logic               hit;
  logic               win_load;
  logic [SELW-1:0]    win;
  logic [SELW-1:0]    need;
  logic               ready;

  assign rs_ext = SB_REGW'(rs);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit      = 1'b0;
    win      = '0;
    win_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb[k].valid && sb[k].rd == rs_ext && rs_used && rs != '0) begin
        hit      = 1'b1;
        win      = SELW'(k);
        win_load = sb[k].is_load;
      end
    end
  end

  assign need   = win_load ? SELW'(READY_LOAD) : SELW'(READY_ALU);
  assign ready  = win >= need;
  assign hazard = hit && !ready;

  always_comb begin
    op_mod  = rf_data;
    fwd_sel = hit ? win : SELW'(DEPTH);
    for (int k = 0; k < DEPTH; k++) begin
      if (hit && ready && win == SELW'(k)) begin
        op_mod = stage_res[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/branch_operand_bypass.sv
// Decode operand bypass: in-flight write scoreboard, per-source forwarding, stall and stall counter.
// Operands are combinational; stall holds decode while the downstream scoreboard keeps shifting.
module branch_operand_bypass
  import bypass_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NSRC       = NSRC_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int REGW       = REGW_DEF,
  parameter int READY_ALU  = READY_ALU_DEF,
  parameter int READY_LOAD = READY_LOAD_DEF,
  parameter int CNTW       = CNTW_DEF
) (
  input logic               clk,
  input logic               rst_n,
  branch_operand_bypass_if.slave bus
);

  localparam int SELW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             slot0;
  logic [NSRC-1:0]       hazard;
  logic [XLEN-1:0]       op_src  [NSRC];
  logic [SELW-1:0]       sel_src [NSRC];
  logic                  stall;
  logic [CNTW-1:0]       cnt;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    bypass_src_sel #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .REGW      (REGW),
      .READY_ALU (READY_ALU),
      .READY_LOAD(READY_LOAD),
      .SELW      (SELW)
    ) u_sel (
      .rs        (bus.id_rs[i*REGW +: REGW]),
      .rs_used   (bus.id_rs_used[i]),
      .sb        (sb),
      .stage_res (bus.stage_res),
      .rf_data   (bus.rf_data[i*XLEN +: XLEN]),
      .op_mod    (op_src[i]),
      .fwd_sel   (sel_src[i]),
      .hazard    (hazard[i])
    );
  end

  always_comb begin
    bus.op_mod  = '0;
    bus.fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      bus.op_mod[i*XLEN +: XLEN]  = op_src[i];
      bus.fwd_sel[i*SELW +: SELW] = sel_src[i];
    end
  end

  // A flushed decode neither stalls nor enters the scoreboard.
  assign stall         = bus.id_valid && !bus.flush && (|hazard);
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt;

  always_comb begin
    slot0 = '0;
    if (bus.id_valid && !stall && !bus.flush && bus.id_regwrite && bus.id_rd != '0) begin
      slot0.valid   = 1'b1;
      slot0.rd      = SB_REGW'(bus.id_rd);
      slot0.is_load = bus.id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb  <= '0;
      cnt <= '0;
    end else begin
      sb[0] <= slot0;
      for (int k = 1; k < DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
      if (stall && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_operand_bypass.sv
// Directed bench for branch_operand_bypass: forwarding, hazards, flush, reset and counter saturation.
module tb_branch_operand_bypass;
  import bypass_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_operand_bypass_if ifc ();
  branch_operand_bypass_if #(.CNTW(4)) ifc2 ();

  branch_operand_bypass dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  branch_operand_bypass #(.CNTW(4)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc2.slave)
  );

  localparam logic [31:0] RF0 = 32'h1111_1111;
  localparam logic [31:0] RF1 = 32'h2222_2222;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic vld, input logic [4:0] rs0, input logic [4:0] rs1,
                     input logic [1:0] used, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic fl);
    ifc.id_valid    = vld;
    ifc.id_rs       = {rs1, rs0};
    ifc.id_rs_used  = used;
    ifc.id_rd       = rd;
    ifc.id_regwrite = rw;
    ifc.id_memread  = mr;
    ifc.flush       = fl;
    #1;
  endtask

  task automatic drain();
    dec(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    ifc.rf_data   = {RF1, RF0};
    ifc.stage_res = {32'hDEAD_BEEF, 32'h0000_00AA, 32'h0000_0055};
    ifc2.id_valid = 1'b0; ifc2.id_rs = '0; ifc2.id_rs_used = '0; ifc2.id_rd = '0;
    ifc2.id_regwrite = 1'b0; ifc2.id_memread = 1'b0; ifc2.flush = 1'b0;
    ifc2.rf_data = '0; ifc2.stage_res = '0;
    dec(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_stall", ifc.stall, 1'b0);
    chk("rst_cnt", ifc.stall_cnt, 16'd0);
    chk("rst_fwd", ifc.fwd_sel, {2'(FWD_RF), 2'(FWD_RF)});
    chk("rst_op", ifc.op_mod, {RF1, RF0});
    rst_n = 1'b1;

    // ALU producer x5 then branch on x5
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("alu_prod_nostall", ifc.stall, 1'b0);
    tick();
    dec(1'b1, 5'd5, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_c1_stall", ifc.stall, 1'b1);
    chk("alu_c1_fwd0", ifc.fwd_sel[1:0], 2'd0);
    chk("alu_c1_fwd1", ifc.fwd_sel[3:2], 2'd3);
    tick();
    chk("alu_c2_stall", ifc.stall, 1'b0);
    chk("alu_c2_fwd0", ifc.fwd_sel[1:0], 2'd1);
    chk("alu_c2_op0", ifc.op_mod[31:0], 32'h0000_00AA);
    chk("alu_c2_cnt", ifc.stall_cnt, 16'd1);
    drain();

    // load x7 then beq x7, x0
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("ld_c1_stall", ifc.stall, 1'b1);
    chk("ld_c1_fwd0", ifc.fwd_sel[1:0], 2'd0);
    tick();
    chk("ld_c2_stall", ifc.stall, 1'b1);
    chk("ld_c2_fwd0", ifc.fwd_sel[1:0], 2'd1);
    tick();
    chk("ld_c3_stall", ifc.stall, 1'b0);
    chk("ld_c3_fwd0", ifc.fwd_sel[1:0], 2'd2);
    chk("ld_c3_op0", ifc.op_mod[31:0], 32'hDEAD_BEEF);
    chk("ld_c3_fwd1", ifc.fwd_sel[3:2], 2'd3);
    chk("ld_c3_op1", ifc.op_mod[63:32], RF1);
    chk("ld_c3_cnt", ifc.stall_cnt, 16'd3);
    drain();

    // two writers of x3 in flight; the younger one must win
    ifc.stage_res = {32'h0000_0011, 32'h0000_0022, 32'h0000_0099};
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd3, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("prio_stall", ifc.stall, 1'b0);
    chk("prio_fwd0", ifc.fwd_sel[1:0], 2'd1);
    chk("prio_op0", ifc.op_mod[31:0], 32'h0000_0022);
    chk("prio_op1", ifc.op_mod[63:32], 32'h0000_0022);
    drain();

    // x0 writer never matches; unused source never stalls
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("x0_fwd0", ifc.fwd_sel[1:0], 2'd3);
    chk("x0_op0", ifc.op_mod[31:0], RF0);
    drain();
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    dec(1'b1, 5'd6, 5'd0, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("unused_stall", ifc.stall, 1'b0);
    chk("unused_fwd0", ifc.fwd_sel[1:0], 2'd3);
    drain();

    // flushed branch on a pending load: no stall, no count, no scoreboard entry
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b1);
    chk("flush_stall", ifc.stall, 1'b0);
    tick();
    dec(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_bubble_fwd", ifc.fwd_sel[1:0], 2'd3);
    chk("flush_bubble_stall", ifc.stall, 1'b0);
    chk("flush_cnt", ifc.stall_cnt, 16'd3);
    drain();

    // reset during a load-use stall
    dec(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rstmid_stall", ifc.stall, 1'b1);
    tick();
    chk("rstmid_cnt", ifc.stall_cnt, 16'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstmid_after_stall", ifc.stall, 1'b0);
    chk("rstmid_after_cnt", ifc.stall_cnt, 16'd0);
    chk("rstmid_after_fwd", ifc.fwd_sel, 4'hF);
    drain();

    // counter saturation on the narrow-counter instance: lw x7,(x7) back to back
    ifc2.id_valid = 1'b1; ifc2.id_rs = {5'd0, 5'd7}; ifc2.id_rs_used = 2'b01;
    ifc2.id_rd = 5'd7; ifc2.id_regwrite = 1'b1; ifc2.id_memread = 1'b1;
    #1;
    repeat (6) tick();
    chk("sat_partial", ifc2.stall_cnt, 4'd4);
    repeat (24) tick();
    chk("sat_full", ifc2.stall_cnt, 4'hF);
    repeat (3) tick();
    chk("sat_hold", ifc2.stall_cnt, 4'hF);
    chk("sat_main_idle", ifc.stall_cnt, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_operand_bypass.md
Name: branch_operand_bypass

Overview:
- Parametrised decode-stage operand bypass and hazard unit.
- Supplies early-resolved branch/compare operands for NSRC source registers, selected from DEPTH downstream pipeline slots or the register file.
- Tracks in-flight destination writes in an internal shift-register scoreboard, so callers no longer decode zero/regwrite/memread per stage.
- Stalls decode when the youngest matching producer has not produced its data yet (load-use or multi-cycle latency). Adds a saturating stall-cycle counter.

Parameters:
- XLEN, 32, operand/result width
- NSRC, 2, number of source operands resolved per cycle
- DEPTH, 3, number of tracked in-flight slots after decode (slot 0 = youngest)
- REGW, 5, register index width
- READY_ALU, 1, first slot index at which a non-load result is valid in stage_res
- READY_LOAD, 2, first slot index at which a load result is valid in stage_res (READY_LOAD >= READY_ALU, both < DEPTH)
- CNTW, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs  in  NSRC*REGW  source register indices, source i at bits [i*REGW +: REGW]
- id_rs_used  in  NSRC  source i is actually read
- id_rd  in  REGW  destination register of the decode instruction
- id_regwrite  in  1  decode instruction writes id_rd
- id_memread  in  1  decode instruction is a load
- flush  in  1  kill the decode instruction (branch taken / redirect)
- rf_data  in  NSRC*XLEN  register-file read data per source
- stage_res  in  DEPTH*XLEN  result currently visible for slot k at [k*XLEN +: XLEN]
- op_mod  out  NSRC*XLEN  resolved operand per source
- fwd_sel  out  NSRC*($clog2(DEPTH+1))  per source: slot index k, or DEPTH = register file
- stall  out  1  hold decode and fetch; a bubble is inserted into slot 0
- stall_cnt  out  CNTW  saturating count of stalled cycles

Behaviour:
- Scoreboard: DEPTH entries of {valid, rd, is_load}.
- Every clock, slot k moves to k+1 and slot DEPTH-1 is discarded. Slots never freeze: the downstream pipeline keeps moving during a decode stall.
- Slot 0 load value:
  - If id_valid && !stall && !flush && id_regwrite && id_rd != 0: {1, id_rd, id_memread}.
  - Otherwise a bubble (valid=0).
- Match for source i at slot k: entry valid, rd == id_rs[i], id_rs_used[i], and id_rs[i] != 0.
- Priority: the lowest-index (youngest) matching slot wins. Older slots are never used when a younger slot matches.
- Ready: the winning slot k is ready if k >= (is_load ? READY_LOAD : READY_ALU).
- Output for source i, combinational, no latency:
  - Winner ready: op_mod = stage_res[k], fwd_sel = k.
  - No match: op_mod = rf_data[i], fwd_sel = DEPTH.
  - Winner not ready: fwd_sel = k, op_mod = rf_data[i] (don't-care, but deterministic).
- stall = id_valid && !flush && (any source whose winner is not ready).
  - flush dominates stall.
  - A stalled instruction re-evaluates each cycle as producers advance.
  - With defaults: a load immediately followed by a branch stalls 2 cycles; an ALU result immediately followed by a branch stalls 1 cycle.
- x0: never matches; the source always reads rf_data (which the register file guarantees is 0).
- stall_cnt:
  - Increments by 1 on every cycle where stall = 1.
  - Saturates at all-ones.
  - Cleared only by reset.
- Reset (rst_n = 0 at a clock edge): all slots invalid, stall_cnt = 0. Combinational outputs then follow: stall = 0, fwd_sel = DEPTH, op_mod = rf_data.
- Reset asserted mid-stall drops all pending producers; the next cycle decodes with no hazard.
- Simultaneous: the decode instruction never forwards from itself. A new slot 0 write becomes visible to decode only on the next cycle.

Decomposition:
- Shared package `bypass_pkg`:
  - typedef `sb_entry_t` {logic valid; logic [REGW-1:0] rd; logic is_load;}
  - constant `FWD_RF` = DEPTH encoding
  - default READY_ALU / READY_LOAD constants
- One natural sub-module: `bypass_src_sel`, instantiated NSRC times via generate. Per-source priority match, ready check and mux; outputs op_mod, fwd_sel and a per-source hazard bit.
- The top level holds the scoreboard shift register, the stall OR-reduction and the counter.

Test Plan:
- ALU chain: cycle 0 decode add x5 (regwrite), cycle 1 branch reading x5 → cycle 1 stall=1, fwd_sel=0; cycle 2 stall=0, fwd_sel=1, op_mod = stage_res[1] = 0x0000_00AA; stall_cnt=1.
- Load-use: lw x7, then beq x7,x0 → stall 2 cycles, then fwd_sel=2, op_mod = stage_res[2] = 0xDEAD_BEEF; rs2 = x0 gives fwd_sel=3, op_mod = rf_data.
- Priority: add x3 (slot 2, value 0x11) and add x3 (slot 1, value 0x22) in flight → op_mod = 0x22, fwd_sel=1; the older value is never selected.
- x0 / unused source: producer writes x0 with regwrite=1 → no match, fwd_sel=3. Matching rd with id_rs_used[i]=0 → no stall.
- flush during hazard: lw x9, then branch on x9 with flush=1 → stall=0, no bubble-induced count increment, slot 0 receives a bubble.
- Reset mid-stall: rst_n=0 during a load-use stall → next cycle stall=0, stall_cnt=0, all fwd_sel=3; stall_cnt saturates at 0xFFFF after 65535+ forced stall cycles (CNTW=16).
